screen_sequencer: RTL and testbench

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

---
 rtl/screen_pkg.sv | 43 ++++
 rtl/screen_sequencer_fade_scaler.sv | 33 +++
 rtl/screen_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_screen_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// screen_pkg: shared types and constants for the screen sequencer slice.
//   scene_t      - scene ROM select encoding (home / stage / game-over)
//   state_t      - sequencer FSM states
//   FADE_MAX     - fade level that means fully black
//   dest_state   - resting state reached once a transition to a scene ends
//   scale_colour - one channel of the fade multiply: (c * (16 - level)) >> 4
package screen_pkg;

    typedef enum logic [1:0] {
        SCENE_HOME  = 2'd0,
        SCENE_STAGE = 2'd1,
        SCENE_OVER  = 2'd2
    } scene_t;

    typedef enum logic [2:0] {
        ST_HOME,
        ST_FADE_OUT,
        ST_FADE_IN,
        ST_PLAY,
        ST_OVER
    } state_t;

    localparam logic [3:0] FADE_MAX = 4'd15;

    function automatic state_t dest_state(input scene_t target);
        case (target)
            SCENE_STAGE: return ST_PLAY;
            SCENE_OVER:  return ST_OVER;
            default:     return ST_HOME;
        endcase
    endfunction

    // Gain is 16..1, so the 9-bit product peaks at 15 * 16 = 240.
    function automatic logic [3:0] scale_colour(input logic [3:0] c,
                                                input logic [3:0] level);
        logic [4:0] gain;
        logic [8:0] prod;
        gain = 5'd16 - {1'b0, level};
        prod = {5'b0, c} * {4'b0, gain};
        return 4'(prod >> 4);
    endfunction

endpackage

// File: rtl/screen_sequencer_fade_scaler.sv
// fade_scaler: registered three-channel brightness scaler.
//   vga_clk                        - pixel clock
//   reset                          - synchronous active-high reset, clears outputs
//   fade_level [3:0]               - 0 = full brightness, 15 = black
//   red_in/green_in/blue_in [3:0]  - palette colour of current pixel
//   red/green/blue [3:0]           - scaled colour, one vga_clk after the inputs
module fade_scaler
    import screen_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [3:0] fade_level,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            red   <= scale_colour(red_in,   fade_level);
            green <= scale_colour(green_in, fade_level);
            blue  <= scale_colour(blue_in,  fade_level);
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: scene flow HOME -> PLAY -> OVER -> HOME with fade
// transitions between scenes.
//   vga_clk, reset        - pixel clock, synchronous active-high reset
//   frame_start           - one-cycle pulse at start of vertical blank
//   start_btn             - start button level (already synchronised)
//   game_over             - game-over level from game logic
//   red_in/green_in/blue_in - pixel colour in
//   scene_sel [1:0]       - scene ROM select (0 home, 1 stage, 2 game-over)
//   fade_level [3:0]      - 0 = full brightness, 15 = black
//   game_run              - high only in PLAY
//   busy                  - high while a scene transition is in progress
//   red/green/blue        - faded colour, 1 cycle latency
// Build option: define SCREEN_FADE_EN for stepped fades; without it a
// transition just swaps the scene on the next frame_start and the colour
// path is a plain register.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP  = 2,
    parameter int unsigned OVER_HOLD_FRAMES = 180
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       start_btn,
    input  logic       game_over,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [1:0] scene_sel,
    output logic [3:0] fade_level,
    output logic       game_run,
    output logic       busy,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    state_t     state, next_state;
    scene_t     target, target_d, scene_q;
    logic       start_btn_q;
    logic       start_edge;
    logic [3:0] frame_cnt;
    logic       step;
    logic [9:0] hold_cnt;
    logic       hold_expired;
    logic       scene_load;
    logic       game_run_d, busy_d;

    assign start_edge   = start_btn & ~start_btn_q;
    assign step         = frame_start && (frame_cnt == 4'(FRAMES_PER_STEP - 1));
    assign hold_expired = (hold_cnt == 10'(OVER_HOLD_FRAMES));
    assign scene_sel    = scene_q;

    // State register plus registered FSM outputs (decoded from next_state
    // so they change on the same edge as the state itself).
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state       <= ST_HOME;
            target      <= SCENE_HOME;
            game_run    <= 1'b0;
            busy        <= 1'b0;
            start_btn_q <= 1'b1;    // a button held through reset is not a press
        end else begin
            state       <= next_state;
            target      <= target_d;
            game_run    <= game_run_d;
            busy        <= busy_d;
            start_btn_q <= start_btn;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        target_d   = target;
        case (state)
            ST_HOME: begin
                if (start_edge) begin
                    next_state = ST_FADE_OUT;
                    target_d   = SCENE_STAGE;
                end
            end
            ST_PLAY: begin
                if (game_over) begin
                    next_state = ST_FADE_OUT;
                    target_d   = SCENE_OVER;
                end
            end
            ST_OVER: begin
                if (start_edge || hold_expired) begin
                    next_state = ST_FADE_OUT;
                    target_d   = SCENE_HOME;
                end
            end
`ifdef SCREEN_FADE_EN
            ST_FADE_OUT: begin
                if (step && fade_level == FADE_MAX)
                    next_state = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                if (step && fade_level == '0)
                    next_state = dest_state(target);
            end
`else
            ST_FADE_OUT: begin
                if (frame_start)
                    next_state = dest_state(target);
            end
            ST_FADE_IN: next_state = ST_HOME;
`endif
            default: next_state = ST_HOME;
        endcase
    end

    // Output decode
    always_comb begin
        game_run_d = (next_state == ST_PLAY);
        busy_d     = (next_state == ST_FADE_OUT) || (next_state == ST_FADE_IN);
    end

`ifdef SCREEN_FADE_EN
    assign scene_load = (state == ST_FADE_OUT) && step && (fade_level == FADE_MAX);
`else
    assign scene_load = (state == ST_FADE_OUT) && frame_start;
`endif

    // Scene select and game-over hold counter. The hold counter is held at
    // zero outside OVER, which clears it on every entry to OVER.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            scene_q  <= SCENE_HOME;
            hold_cnt <= '0;
        end else begin
            if (scene_load)
                scene_q <= target;
            if (state != ST_OVER)
                hold_cnt <= '0;
            else if (frame_start && !hold_expired)
                hold_cnt <= hold_cnt + 10'd1;
        end
    end

    // Frame counter runs only while fading; it is zero on fade entry, so a
    // frame_start coinciding with the triggering event is not counted.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if ((state == ST_FADE_OUT) || (state == ST_FADE_IN)) begin
            if (frame_start)
                frame_cnt <= step ? 4'd0 : frame_cnt + 4'd1;
        end else begin
            frame_cnt <= '0;
        end
    end

`ifdef SCREEN_FADE_EN
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            fade_level <= '0;
        end else if (step) begin
            if (state == ST_FADE_OUT && fade_level != FADE_MAX)
                fade_level <= fade_level + 4'd1;
            else if (state == ST_FADE_IN && fade_level != '0)
                fade_level <= fade_level - 4'd1;
        end
    end
`else
    // Level 0 gives unity gain, so the scaler reduces to a plain register.
    assign fade_level = '0;
`endif

    fade_scaler u_fade_scaler (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .fade_level (fade_level),
        .red_in     (red_in),
        .green_in   (green_in),
        .blue_in    (blue_in),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed stimulus with a queue-based scoreboard.
// Stimulus pushes the expected outputs for a given cycle; a monitor on the
// falling edge pops and compares. Runs the fade or the no-fade scenario
// depending on SCREEN_FADE_EN.
module tb_screen_sequencer;

    logic       vga_clk;
    logic       reset;
    logic       frame_start;
    logic       start_btn;
    logic       game_over;
    logic [3:0] red_in, green_in, blue_in;
    logic [1:0] scene_sel;
    logic [3:0] fade_level;
    logic       game_run, busy;
    logic [3:0] red, green, blue;

    screen_sequencer #(
        .FRAMES_PER_STEP  (2),
        .OVER_HOLD_FRAMES (4)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .start_btn   (start_btn),
        .game_over   (game_over),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .scene_sel   (scene_sel),
        .fade_level  (fade_level),
        .game_run    (game_run),
        .busy        (busy),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int unsigned cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int unsigned cyc;
        logic [1:0]  sc;
        logic [3:0]  fl;
        logic        run;
        logic        bsy;
        logic [3:0]  r, g, b;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge vga_clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (scene_sel !== e.sc || fade_level !== e.fl || game_run !== e.run ||
                busy !== e.bsy || red !== e.r || green !== e.g || blue !== e.b) begin
                fails++;
                $display("FAIL %s: got scene=%0d fade=%0d run=%0b busy=%0b rgb=%0d/%0d/%0d, want scene=%0d fade=%0d run=%0b busy=%0b rgb=%0d/%0d/%0d",
                         e.name, scene_sel, fade_level, game_run, busy, red, green, blue,
                         e.sc, e.fl, e.run, e.bsy, e.r, e.g, e.b);
            end
        end
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press();
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
    endtask

    task automatic expect_now(input string nm, input logic [1:0] sc, input logic [3:0] fl,
                              input logic run, input logic bsy,
                              input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        exp_t x;
        x.name = nm; x.cyc = cyc; x.sc = sc; x.fl = fl; x.run = run; x.bsy = bsy;
        x.r = r; x.g = g; x.b = b;
        exp_q.push_back(x);
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        start_btn   = 1'b1;
        game_over   = 1'b0;
`ifdef SCREEN_FADE_EN
        red_in = 4'd15; green_in = 4'd15; blue_in = 4'd15;
        tick();
        expect_now("reset", 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        expect_now("post_reset", 0, 0, 0, 0, 15, 15, 15);
        frame();
        tick();
        expect_now("held_no_start", 0, 0, 0, 0, 15, 15, 15);
        press();
        expect_now("press", 0, 0, 0, 1, 15, 15, 15);
        frame(); tick();
        expect_now("one_frame", 0, 0, 0, 1, 15, 15, 15);
        frame(); tick();
        expect_now("two_frames", 0, 1, 0, 1, 14, 14, 14);
        frames(14); tick();
        expect_now("level8", 0, 8, 0, 1, 7, 7, 7);
        frames(14); tick();
        expect_now("level15", 0, 15, 0, 1, 0, 0, 0);
        frame(); tick();
        expect_now("frame31_hold", 0, 15, 0, 1, 0, 0, 0);
        frame(); tick();
        expect_now("scene_load", 1, 15, 0, 1, 0, 0, 0);
        frames(2); tick();
        expect_now("fadein_14", 1, 14, 0, 1, 1, 1, 1);
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        tick();
        expect_now("ignore_in_fade_in", 1, 14, 0, 1, 1, 1, 1);
        frames(28); tick();
        expect_now("fadein_0", 1, 0, 0, 1, 15, 15, 15);
        frame(); tick();
        expect_now("frame63_hold", 1, 0, 0, 1, 15, 15, 15);
        frame(); tick();
        expect_now("play", 1, 0, 1, 0, 15, 15, 15);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        expect_now("game_over_fade", 1, 0, 0, 1, 15, 15, 15);
        frames(12); tick();
        expect_now("level6", 1, 6, 0, 1, 9, 9, 9);
        reset = 1'b1;
        tick();
        expect_now("reset_mid_fade", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        expect_now("home_after_reset", 0, 0, 0, 0, 15, 15, 15);
`else
        red_in = 4'd9; green_in = 4'd5; blue_in = 4'd15;
        tick();
        expect_now("reset", 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        expect_now("post_reset", 0, 0, 0, 0, 9, 5, 15);
        frame();
        expect_now("held_no_start", 0, 0, 0, 0, 9, 5, 15);
        press();
        expect_now("press", 0, 0, 0, 1, 9, 5, 15);
        frame();
        expect_now("play", 1, 0, 1, 0, 9, 5, 15);
        red_in = 4'd3;
        expect_now("colour_delay_old", 1, 0, 1, 0, 9, 5, 15);
        tick();
        expect_now("colour_delay_new", 1, 0, 1, 0, 3, 5, 15);
        // game_over together with frame_start: transition, frame not counted
        game_over   = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        expect_now("go_with_frame", 1, 0, 0, 1, 3, 5, 15);
        tick();
        game_over = 1'b0;
        expect_now("go_ignored_in_fade", 1, 0, 0, 1, 3, 5, 15);
        frame();
        expect_now("over", 2, 0, 0, 0, 3, 5, 15);
        frames(4);
        expect_now("hold_4_frames", 2, 0, 0, 0, 3, 5, 15);
        tick();
        expect_now("hold_expire", 2, 0, 0, 1, 3, 5, 15);
        frame();
        expect_now("home_by_hold", 0, 0, 0, 0, 3, 5, 15);
        press();
        expect_now("press2", 0, 0, 0, 1, 3, 5, 15);
        frame();
        expect_now("play2", 1, 0, 1, 0, 3, 5, 15);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        frame();
        expect_now("over2", 2, 0, 0, 0, 3, 5, 15);
        frames(2);
        press();
        expect_now("over_start", 2, 0, 0, 1, 3, 5, 15);
        frame();
        expect_now("home_by_start", 0, 0, 0, 0, 3, 5, 15);
        press();
        expect_now("press3", 0, 0, 0, 1, 3, 5, 15);
        reset = 1'b1;
        tick();
        expect_now("reset_mid", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        frame();
        expect_now("home_after_reset", 0, 0, 0, 0, 3, 5, 15);
`endif
        tick();
        tick();
        if (exp_q.size() != 0) begin
            fails  += exp_q.size();
            checks += exp_q.size();
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
